byte_lane_data_memory: RTL and testbench

// - Parametrised data memory for the pipelined MIPS core; successor to the single-cycle word-only data memory.
// - Adds byte, halfword and word loads/stores with sign/zero extension, a valid/ready request handshake,

---
 rtl/dm_pkg.sv | 13 +
 rtl/byte_lane_align.sv | 49 ++++
 rtl/byte_lane_data_memory.sv | 147 ++++++++++++++
 tb/tb_byte_lane_data_memory.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared encodings for the byte-lane data memory: access sizes and FSM states.
package dm_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_EXEC = 2'b10;

endpackage

// File: rtl/byte_lane_align.sv
// Combinational lane steering: store mask and replicated store data,
// load extract/extend, and misalignment / reserved-size detection.
module byte_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_extend,
    input  logic [31:0] write_data,
    input  logic [31:0] read_word,
    output logic [3:0]  byte_mask,
    output logic [31:0] lane_data,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted;

    always_comb begin
        shifted    = read_word >> {addr_lo, 3'b000};
        byte_mask  = '0;
        lane_data  = '0;
        load_data  = '0;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                byte_mask = 4'b0001 << addr_lo;
                lane_data = {4{write_data[7:0]}};
                load_data = {{24{sign_extend & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                byte_mask  = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data  = {2{write_data[15:0]}};
                load_data  = {{16{sign_extend & shifted[15]}}, shifted[15:0]};
                misaligned = addr_lo[0];
            end
            SIZE_WORD: begin
                byte_mask  = 4'b1111;
                lane_data  = write_data;
                load_data  = read_word;
                misaligned = (addr_lo != 2'b00);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/byte_lane_data_memory.sv
// Data memory with byte/half/word access, valid/ready request handshake,
// configurable wait states and misaligned/out-of-range error reporting.
module byte_lane_data_memory
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  request_valid,
    output logic                  request_ready,
    input  logic                  write_enabled,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [1:0]            size,
    input  logic                  sign_extend,
    input  logic [31:0]           write_input,
    output logic                  done,
    output logic [31:0]           read_result,
    output logic                  access_error
);

    localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam bit          NO_WAIT = (WAIT_CYCLES == 0);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, se_q, err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic [31:0]           wdata_q, rdata_q;
    logic [31:0]           mem_q [DEPTH_WORDS];

    logic                  idle, accept, enter_exec;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [1:0]            cur_size;
    logic                  cur_we, cur_se, cur_err, in_range;
    logic [31:0]           cur_wdata, cur_word;
    logic [IDX_W-1:0]      cur_idx;
    logic [3:0]            byte_mask;
    logic [31:0]           lane_data, load_data;
    logic                  misaligned;

    assign idle          = (state_q == ST_IDLE);
    assign accept        = idle && request_valid;
    assign request_ready = idle;
    assign done          = (state_q == ST_EXEC);
    assign access_error  = err_q;
    assign read_result   = rdata_q;

    // With no wait states EXEC is entered on the accept edge, before the
    // request is latched, so the lane logic must see the live inputs in IDLE.
    always_comb begin
        cur_addr  = idle ? address       : addr_q;
        cur_size  = idle ? size          : size_q;
        cur_we    = idle ? write_enabled : we_q;
        cur_se    = idle ? sign_extend   : se_q;
        cur_wdata = idle ? write_input   : wdata_q;
        in_range  = cur_addr[ADDR_WIDTH-1:2] < (ADDR_WIDTH-2)'(DEPTH_WORDS);
        cur_idx   = cur_addr[IDX_W+1:2];
        cur_word  = in_range ? mem_q[cur_idx] : '0;
        cur_err   = misaligned || !in_range;
    end

    byte_lane_align u_align (
        .addr_lo     (cur_addr[1:0]),
        .size        (cur_size),
        .sign_extend (cur_se),
        .write_data  (cur_wdata),
        .read_word   (cur_word),
        .byte_mask   (byte_mask),
        .lane_data   (lane_data),
        .load_data   (load_data),
        .misaligned  (misaligned)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_exec = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (request_valid) begin
                    if (NO_WAIT) begin
                        state_d    = ST_EXEC;
                        enter_exec = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = ST_EXEC;
                    enter_exec = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_EXEC: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            se_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= write_enabled;
                se_q    <= sign_extend;
                addr_q  <= address;
                size_q  <= size;
                wdata_q <= write_input;
            end
            if (enter_exec) begin
                err_q <= cur_err;
                if (!cur_err && !cur_we) begin
                    rdata_q <= load_data;
                end
            end
            if (done && we_q && !err_q) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (byte_mask[b]) begin
                        mem_q[cur_idx][8*b +: 8] <= lane_data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_byte_lane_data_memory.sv
// Random and directed checks of three memory instances (0, 1 and 3 wait
// states) against an arithmetic reference model of memory and load results.
module tb_byte_lane_data_memory;

    logic        clk, rst_n;
    logic [2:0]  valid;
    logic        we, se;
    logic [31:0] addr, wd;
    logic [1:0]  sz;
    logic        rdy [3];
    logic        dn  [3];
    logic        er  [3];
    logic [31:0] rr  [3];

    int unsigned WAITS [3] = '{0, 1, 3};
    logic [31:0] mdl_mem [3][1024];
    logic [31:0] mdl_rr  [3];
    int          errors = 0;
    int          checks = 0;

    byte_lane_data_memory #(.DEPTH_WORDS(1024), .ADDR_WIDTH(32), .WAIT_CYCLES(0)) u_w0 (
        .clock(clk), .reset(rst_n), .request_valid(valid[0]), .request_ready(rdy[0]),
        .write_enabled(we), .address(addr), .size(sz), .sign_extend(se), .write_input(wd),
        .done(dn[0]), .read_result(rr[0]), .access_error(er[0]));
    byte_lane_data_memory #(.DEPTH_WORDS(1024), .ADDR_WIDTH(32), .WAIT_CYCLES(1)) u_w1 (
        .clock(clk), .reset(rst_n), .request_valid(valid[1]), .request_ready(rdy[1]),
        .write_enabled(we), .address(addr), .size(sz), .sign_extend(se), .write_input(wd),
        .done(dn[1]), .read_result(rr[1]), .access_error(er[1]));
    byte_lane_data_memory #(.DEPTH_WORDS(1024), .ADDR_WIDTH(32), .WAIT_CYCLES(3)) u_w3 (
        .clock(clk), .reset(rst_n), .request_valid(valid[2]), .request_ready(rdy[2]),
        .write_enabled(we), .address(addr), .size(sz), .sign_extend(se), .write_input(wd),
        .done(dn[2]), .read_result(rr[2]), .access_error(er[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic bit mdl_err(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0)
               || (a / 4 >= 1024);
    endfunction

    function automatic logic [31:0] mdl_load(input int d, input logic [31:0] a,
                                             input logic [1:0] s, input bit sgn);
        logic [31:0] w;
        int          v;
        w = mdl_mem[d][a / 4] >> (8 * (a % 4));
        if (s == 2'd2) return mdl_mem[d][a / 4];
        if (s == 2'd0) begin
            v = int'(w & 32'hFF);
            if (sgn && v >= 128) v -= 256;
        end else begin
            v = int'(w & 32'hFFFF);
            if (sgn && v >= 32768) v -= 65536;
        end
        return 32'(v);
    endfunction

    task automatic mdl_store(input int d, input logic [31:0] a, input logic [1:0] s,
                             input logic [31:0] data);
        logic [31:0] m;
        int unsigned k;
        k = 8 * (a % 4);
        m = (s == 2'd0) ? 32'hFF : (s == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        mdl_mem[d][a / 4] = (mdl_mem[d][a / 4] & ~(m << k)) | ((data & m) << k);
    endtask

    task automatic mdl_clear();
        for (int d = 0; d < 3; d++) begin
            mdl_rr[d] = '0;
            for (int i = 0; i < 1024; i++) mdl_mem[d][i] = '0;
        end
    endtask

    task automatic req(input int d, input bit w, input logic [31:0] a, input logic [1:0] s,
                       input bit sgn, input logic [31:0] data, input bit hold);
        int unsigned n;
        bit          seen, e;
        @(negedge clk);
        check("ready_idle", 32'(rdy[d]), 32'd1);
        we = w; addr = a; sz = s; se = sgn; wd = data; valid[d] = 1'b1;
        @(posedge clk);
        #1;
        if (hold) begin
            we = 1'b1; addr = a + 32'h100; sz = 2'd2; wd = 32'h5A5A_5A5A;
        end else begin
            valid[d] = 1'b0;
        end
        e = mdl_err(a, s);
        if (!e && !w) mdl_rr[d] = mdl_load(d, a, s, sgn);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (dn[d]) seen = 1'b1;
            else check("ready_busy", 32'(rdy[d]), 32'd0);
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        valid[d] = 1'b0;
        check("latency", n, WAITS[d] + 1);
        check("ready_exec", 32'(rdy[d]), 32'd0);
        check("access_error", 32'(er[d]), 32'(e));
        check("read_result", rr[d], mdl_rr[d]);
        if (!e && w) mdl_store(d, a, s, data);
        @(negedge clk);
        check("done_pulse", 32'(dn[d]), 32'd0);
        check("ready_after", 32'(rdy[d]), 32'd1);
    endtask

    task automatic reset_mid(input int d, input int extra);
        @(negedge clk);
        we = 1'b1; addr = 32'h40; sz = 2'd2; se = 1'b0; wd = 32'hCAFE_F00D; valid[d] = 1'b1;
        @(posedge clk);
        #1;
        valid[d] = 1'b0;
        repeat (extra) @(posedge clk);
        #1;
        check("mid_wait_busy", 32'(rdy[d]), 32'd0);
        rst_n = 1'b0;
        mdl_clear();
        repeat (2) begin
            @(negedge clk);
            check("rst_done", 32'(dn[d]), 32'd0);
            check("rst_ready", 32'(rdy[d]), 32'd1);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_late_done", 32'(dn[d]), 32'd0);
        end
        req(d, 1'b0, 32'h40, 2'd2, 1'b0, '0, 1'b0);
        check("after_rst_40", rr[d], 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; valid = '0; we = 1'b0; se = 1'b0; addr = '0; sz = '0; wd = '0;
        mdl_clear();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_ready", 32'(rdy[d]), 32'd1);
            check("rst_done", 32'(dn[d]), 32'd0);
            check("rst_err", 32'(er[d]), 32'd0);
            check("rst_rdata", rr[d], 32'd0);
        end
        rst_n = 1'b1;

        for (int d = 0; d < 3; d++) begin
            req(d, 1'b0, 32'h0, 2'd2, 1'b0, '0, 1'b0);
            check("load0", rr[d], 32'h0);
            req(d, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0);
            req(d, 1'b0, 32'h10, 2'd0, 1'b1, '0, 1'b0);
            check("lb_10", rr[d], 32'hFFFF_FFEF);
            req(d, 1'b0, 32'h11, 2'd0, 1'b1, '0, 1'b0);
            check("lb_11", rr[d], 32'hFFFF_FFBE);
            req(d, 1'b0, 32'h12, 2'd0, 1'b1, '0, 1'b0);
            check("lb_12", rr[d], 32'hFFFF_FFAD);
            req(d, 1'b0, 32'h13, 2'd0, 1'b1, '0, 1'b0);
            check("lb_13", rr[d], 32'hFFFF_FFDE);
            req(d, 1'b0, 32'h13, 2'd0, 1'b0, '0, 1'b0);
            check("lbu_13", rr[d], 32'h0000_00DE);
            req(d, 1'b1, 32'h20, 2'd2, 1'b0, 32'h1122_3344, 1'b0);
            req(d, 1'b1, 32'h22, 2'd1, 1'b0, 32'h0000_8001, 1'b0);
            req(d, 1'b0, 32'h20, 2'd2, 1'b1, '0, 1'b0);
            check("lw_20", rr[d], 32'h8001_3344);
            req(d, 1'b0, 32'h22, 2'd1, 1'b1, '0, 1'b0);
            check("lh_22", rr[d], 32'hFFFF_8001);
            req(d, 1'b1, 32'h05, 2'd2, 1'b0, 32'hFFFF_FFFF, 1'b0);
            req(d, 1'b0, 32'h21, 2'd1, 1'b1, '0, 1'b0);
            req(d, 1'b0, 32'h1000, 2'd2, 1'b0, '0, 1'b0);
            req(d, 1'b0, 32'h20, 2'd3, 1'b0, '0, 1'b0);
            check("err_keeps_rdata", rr[d], 32'hFFFF_8001);
            req(d, 1'b0, 32'h04, 2'd2, 1'b0, '0, 1'b0);
            check("misaligned_no_write", rr[d], 32'h0);
            req(d, 1'b0, 32'h10, 2'd2, 1'b0, '0, 1'b1);
            req(d, 1'b0, 32'h110, 2'd2, 1'b0, '0, 1'b0);
            check("held_req_ignored", rr[d], 32'h0);
        end

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 40; i++) begin
                logic [31:0] ra;
                ra = ($urandom_range(0, 15) == 0) ? 32'h1000 + $urandom_range(0, 7)
                                                  : 32'($urandom_range(0, 63));
                req(d, 1'($urandom_range(0, 1)), ra, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom, 1'b0);
            end
        end

        reset_mid(1, 0);
        reset_mid(2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
        $fatal(1, "simulation time limit");
    end

endmodule
